// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: drives a synchronous instruction memory,
// tracks the pc of the presented instruction, handles stall, branch and halt.
module imem_fetch_ctrl #(
  parameter logic [12:0] RESET_VECTOR = 13'h0000,
  parameter logic [31:0] HALT_WORD    = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [12:0] branch_target,
  input  logic        resume,
  output logic [12:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] inst,
  output logic [12:0] inst_pc,
  output logic        inst_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t      state, state_nxt;
  logic [12:0] pc, pc_nxt, pc_inc;
  logic        accept;

  // Sequential word address; wraps from the top of the 13-bit space to zero.
  function automatic logic [12:0] wrap_inc(input logic [12:0] a);
    return a + 13'd1;
  endfunction

  assign pc_inc  = wrap_inc(pc);
  assign inst    = imem_data;
  assign inst_pc = pc;

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    imem_addr  = pc;
    inst_valid = 1'b0;
    halted     = 1'b0;
    accept     = 1'b0;
    case (state)
      BOOT: begin
        imem_addr = RESET_VECTOR;
        pc_nxt    = RESET_VECTOR;
        state_nxt = RUN;
      end
      RUN: begin
        inst_valid = 1'b1;
        accept     = ~stall;
        imem_addr  = branch_taken ? branch_target : (stall ? pc : pc_inc);
        // An accepted halt word freezes pc so resume continues at pc+1.
        if (accept && !branch_taken && imem_data == HALT_WORD)
          state_nxt = HALT;
        else
          pc_nxt = imem_addr;
      end
      HALT: begin
        halted = 1'b1;
        if (branch_taken) begin
          imem_addr = branch_target;
          pc_nxt    = branch_target;
          state_nxt = RUN;
        end else if (resume) begin
          imem_addr = pc_inc;
          pc_nxt    = pc_inc;
          state_nxt = RUN;
        end
      end
      default: begin
        imem_addr = RESET_VECTOR;
        state_nxt = BOOT;
      end
    endcase
    if (rst) begin
      state_nxt  = BOOT;
      pc_nxt     = RESET_VECTOR;
      imem_addr  = RESET_VECTOR;
      inst_valid = 1'b0;
      halted     = 1'b0;
      accept     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state <= state_nxt;
    pc    <= pc_nxt;
    if (rst)
      fetch_count <= 32'd0;
    else if (accept)
      fetch_count <= fetch_count + 32'd1;
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: directed scenarios then random traffic,
// predicted by a transaction-level model of the fetch rules.
module tb_imem_fetch_ctrl;
  localparam logic [12:0] RV   = 13'h0000;
  localparam logic [31:0] HALT = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [12:0] branch_target = 13'h0;
  logic        resume = 1'b0;
  logic [12:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] inst;
  logic [12:0] inst_pc;
  logic        inst_valid;
  logic        halted;
  logic [31:0] fetch_count;

  imem_fetch_ctrl #(.RESET_VECTOR(RV), .HALT_WORD(HALT)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .resume(resume), .imem_addr(imem_addr),
    .imem_data(imem_data), .inst(inst), .inst_pc(inst_pc),
    .inst_valid(inst_valid), .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:8191];
  always @(posedge clk) imem_data <= mem[imem_addr];

  typedef struct {
    logic [12:0] addr;
    logic        valid;
    logic        hlt;
    logic [12:0] pc;
    logic [31:0] inst;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int fails  = 0;

  // Model: mode 0 = booting, 1 = fetching, 2 = halted.
  int          m_mode = 0;
  int          m_pc   = 0;
  logic [31:0] m_cnt  = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("imem_addr", 32'(imem_addr), 32'(e.addr));
      chk("inst_valid", 32'(inst_valid), 32'(e.valid));
      chk("halted", 32'(halted), 32'(e.hlt));
      chk("fetch_count", fetch_count, e.cnt);
      if (e.valid) begin
        chk("inst_pc", 32'(inst_pc), 32'(e.pc));
        chk("inst", inst, e.inst);
      end
    end
  end

  task automatic step(input bit r, input bit s, input bit b, input int t, input bit res);
    exp_t e;
    int   nxt;
    @(posedge clk);
    #1;
    rst = r; stall = s; branch_taken = b; branch_target = 13'(t); resume = res;
    nxt = (m_pc + 1) % 8192;
    e.pc   = 13'(m_pc);
    e.cnt  = m_cnt;
    e.inst = mem[m_pc];
    e.valid = !r && m_mode == 1;
    e.hlt   = !r && m_mode == 2;
    if (r || m_mode == 0)   e.addr = RV;
    else if (b)             e.addr = 13'(t);
    else if (m_mode == 1)   e.addr = s ? 13'(m_pc) : 13'(nxt);
    else                    e.addr = res ? 13'(nxt) : 13'(m_pc);
    q.push_back(e);
    if (r) begin
      m_mode = 0; m_pc = int'(RV); m_cnt = 32'd0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_pc = int'(RV);
    end else if (m_mode == 1) begin
      if (!s) m_cnt = m_cnt + 32'd1;
      if (!s && !b && mem[m_pc] == HALT) m_mode = 2;
      else m_pc = int'(e.addr);
    end else if (b || res) begin
      m_mode = 1; m_pc = int'(e.addr);
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) begin
      logic [31:0] w;
      w = $urandom;
      if (w == HALT) w = 32'h0;
      if (i >= 32'h200 && i < 32'h1F00 && $urandom_range(0, 31) == 0) w = HALT;
      mem[i] = w;
    end
    mem[4] = HALT;

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);                       // boot cycle
    repeat (2) step(0, 0, 0, 0, 0);            // pc 0, 1
    repeat (3) step(0, 1, 0, 0, 0);            // pc 2 held
    repeat (3) step(0, 0, 0, 0, 0);            // pc 2, 3, 4 (halt word)
    repeat (2) step(0, 1, 0, 0, 0);            // halted, stall ignored
    step(0, 0, 0, 0, 1);                       // resume
    step(0, 1, 1, 32'h100, 0);                 // branch under stall at pc 5
    repeat (2) step(0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h1FFF, 0);
    repeat (3) step(0, 0, 0, 0, 0);            // 0x1FFF, 0x0000, 0x0001
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);                       // reset mid-stall
    repeat (2) step(0, 0, 0, 0, 0);
    step(0, 0, 1, 4, 0);
    step(0, 0, 0, 0, 0);                       // halt word at 4
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);                       // reset during halt
    repeat (3) step(0, 0, 0, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      bit r, s, b, res;
      int t;
      r   = ($urandom_range(0, 199) == 0);
      s   = ($urandom_range(0, 3) == 0);
      b   = ($urandom_range(0, 9) == 0);
      res = ($urandom_range(0, 2) == 0);
      t   = ($urandom_range(0, 3) == 0) ? 32'h1FFF : int'($urandom_range(0, 8191));
      step(r, s, b, t, res);
    end

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 13'h0000, word address of first fetch after reset.
REQ-002 SHALL have parameter HALT_WORD, default 32'hFFFFFFFF, instruction encoding that halts fetch.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port stall  input  1  downstream cannot accept inst this cycle.
REQ-006 SHALL have port branch_taken  input  1  redirect fetch to branch_target.
REQ-007 SHALL have port branch_target  input  13  redirect word address.
REQ-008 SHALL have port resume  input  1  leave HALT, continue sequentially.
REQ-009 SHALL have port imem_addr  output  13  word address to synchronous instruction memory; combinational.
REQ-010 SHALL have port imem_data  input  32  memory read data, valid one cycle after address presented.
REQ-011 SHALL have port inst  output  32  current instruction; equals imem_data.
REQ-012 SHALL have port inst_pc  output  13  word address of inst.
REQ-013 SHALL have port inst_valid  output  1  inst/inst_pc meaningful.
REQ-014 SHALL have port halted  output  1  high while in HALT.
REQ-015 SHALL have port fetch_count  output  32  number of accepted instructions.

Function
REQ-016 SHALL implement FSM states BOOT, RUN, HALT; registered pc (= inst_pc), fetch_count.
REQ-017 BOOT: imem_addr=RESET_VECTOR, inst_valid=0, inputs ignored; next state RUN, pc<=RESET_VECTOR.
REQ-018 RUN: inst_valid=1; imem_addr = branch_taken ? branch_target : (stall ? pc : pc+1); pc<=imem_addr each cycle.
REQ-019 Priority in RUN: branch_taken > stall > sequential; branch under stall still redirects.
REQ-020 Accept = state RUN & inst_valid & ~stall; fetch_count increments by 1 per accept, wraps 2^32-1 -> 0.
REQ-021 Stall SHALL hold inst, inst_pc stable (same address re-presented; memory is read-only).
REQ-022 pc+1 SHALL wrap 13'h1FFF -> 13'h0000, no flag.
REQ-023 RUN, imem_data==HALT_WORD, ~stall, ~branch_taken: halt word is accepted (counted) and next state HALT, pc held.
REQ-024 HALT_WORD under stall SHALL not halt until accepted; with branch_taken the branch wins, no halt.
REQ-025 HALT: inst_valid=0, halted=1, imem_addr=pc, stall ignored, fetch_count frozen.
REQ-026 HALT exit: branch_taken -> RUN, imem_addr=branch_target; else resume -> RUN, imem_addr=pc+1; branch beats resume.
REQ-027 Latency: instruction at address A appears on inst exactly one cycle after imem_addr=A.
REQ-028 halted SHALL be 0 in BOOT and RUN.

Reset
REQ-029 While rst=1: next state BOOT, pc<=RESET_VECTOR, fetch_count<=0; outputs during rst: inst_valid=0, halted=0, imem_addr=RESET_VECTOR.
REQ-030 rst SHALL override all other inputs in any state, including mid-stall and HALT.
REQ-031 First valid instruction SHALL appear 2 cycles after rst deasserts (BOOT, then RUN).

Verification
REQ-032 Reset, mem[0..3]=distinct words, no stall -> inst_valid rises 2nd cycle after rst low; inst_pc 0,1,2,3; fetch_count 1,2,3,4 after each accept.
REQ-033 stall high 3 cycles at inst_pc=2 -> inst/inst_pc held at mem[2]/2, fetch_count unchanged; release -> inst_pc=3 next cycle.
REQ-034 branch_taken with target 13'h0100 at inst_pc=5, stall=1 same cycle -> next cycle inst_pc=0x100, inst=mem[0x100].
REQ-035 mem[4]=32'hFFFFFFFF -> accepted at inst_pc=4, then halted=1, inst_valid=0, fetch_count=5; resume -> inst_pc=5 valid next cycle.
REQ-036 branch to 13'h1FFF, no stall -> inst_pc 0x1FFF then 0x0000.
REQ-037 rst asserted during HALT and during stall -> BOOT next cycle, fetch_count=0, halted=0, imem_addr=RESET_VECTOR.
